rv_tag_access_arb: RTL
======================

RV_TAG_ACCESS_ARB -- requirements
Module: rv_tag_access_arb

Interface
REQ-001 SHALL take parameter CACHE_SIZE, default 16384: cache size in bytes.
REQ-002 SHALL take parameter CACHE_LINE_SIZE, default 1: line size in bytes.
REQ-003 SHALL take parameter NUM_BANKS, default 1: bank count.
REQ-004 SHALL take parameter TAG_WIDTH, default 20: stored tag width.
REQ-005 SHALL have port clk  input  1  clock; every flop is rising-edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush_valid  input  1  flush stream valid; the stream has no back-pressure.
REQ-008 SHALL have port flush_addr  input  LINE_SELECT_BITS  line to invalidate.
REQ-009 SHALL have port core_req_valid  input  1  core tag request valid.
REQ-010 SHALL have port core_req_ready  output  1  request accepted when valid&ready.
REQ-011 SHALL have port core_req_line  input  LINE_SELECT_BITS  line index.
REQ-012 SHALL have port core_req_rw  input  1  1=tag write, 0=lookup.
REQ-013 SHALL have port core_req_tag  input  TAG_WIDTH  tag to write.
REQ-014 SHALL have port tag_ready  input  1  tag array can accept a core access.
REQ-015 SHALL have outputs tag_en 1, tag_wr 1, tag_line LINE_SELECT_BITS, tag_wvalid 1 and tag_wtag TAG_WIDTH, which drive the tag-array port.
REQ-016 SHALL have outputs flush_done 1 (all lines invalidated) and proto_err 1 (sticky protocol error).
REQ-017 SHALL have output stall_cnt  32  core stall cycle count.

Function
REQ-018 SHALL have two states: FLUSH (the reset state) and RUN.
REQ-019 In FLUSH with flush_valid=1, SHALL drive the tag port combinationally in the same cycle: tag_en=1, tag_wr=1, tag_line=flush_addr, tag_wvalid=0, tag_wtag=0; tag_ready is ignored.
REQ-020 SHALL increment a LINE_SELECT_BITS+1-bit line counter once per accepted flush beat.
REQ-021 SHALL move FLUSH->RUN on the clock edge that accepts a flush beat while the counter equals 2^LINE_SELECT_BITS-1.
REQ-022 SHALL drive flush_done as a registered flag, 1 from the first RUN cycle until reset.
REQ-023 In FLUSH with flush_valid=0, SHALL drive tag_en=0.
REQ-024 SHALL hold a one-entry request register: core_req_ready = !req_vld | issue, where issue = req_vld & tag_ready & (state==RUN).
REQ-025 SHALL let a request accepted at edge N drive the tag port in cycle N+1 (tag_en=1, tag_wr=rw, tag_wvalid=rw, tag_wtag=tag); issue at edge N+1 plus a new accept gives throughput of 1 per cycle.
REQ-026 Capture and issue in the same cycle SHALL overwrite the register; issue without capture SHALL clear req_vld.
REQ-027 In FLUSH, one core request MAY be captured; it SHALL be held and issued in the first RUN cycle whose tag_ready=1.
REQ-028 SHALL hold tag_en=0 and the register unchanged while tag_ready=0 in RUN.
REQ-029 flush_valid=1 in RUN SHALL set proto_err (sticky until reset); the beat is ignored.

Reset
REQ-030 Reset SHALL force state=FLUSH, counter=0, req_vld=0, flush_done=0, proto_err=0, stall_cnt=0.
REQ-031 With reset=1, all tag_* outputs and core_req_ready SHALL be 0.
REQ-032 Reset mid-flush or mid-request SHALL discard all progress, and the flush SHALL restart from line 0.

Configuration
REQ-033 With RV_TAG_ARB_STALL_CNT_EN defined, stall_cnt SHALL increment on every cycle with core_req_valid=1 and core_req_ready=0, saturating at 32'hFFFFFFFF.
REQ-034 Without RV_TAG_ARB_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter flops SHALL be inferred.

Structure
REQ-035 The LINE_SELECT_BITS derivation and the state encoding SHALL live in the shared cache define/package file.
REQ-036 The request register SHALL be a sub-module rv_tag_req_buf; the FSM and mux SHALL stay in the top module.

Verification
All scenarios use CACHE_SIZE=64, CACHE_LINE_SIZE=4, NUM_BANKS=1, so LINE_SELECT_BITS=4 and there are 16 lines.
REQ-037 Reset, then flush_valid=1 with flush_addr 0..15 over 16 cycles -> tag_wr=1 and tag_wvalid=0 each cycle; flush_done=1 in cycle 17.
REQ-038 core_req_valid=1 from cycle 2 of flush (line 5, rw=1, tag 0xABC) -> one accept, then ready=0; tag port shows line 5, tag 0xABC in the first RUN cycle.
REQ-039 In RUN, 4 back-to-back reads on lines 1..4 with tag_ready=1 -> tag_en=1 on 4 consecutive cycles, each 1 cycle after its accept.
REQ-040 In RUN, tag_ready=0 for 3 cycles with a request pending -> tag_en=0 and ready=0 for 3 cycles; the request is issued on the 4th; with the macro defined, stall_cnt=3.
REQ-041 Reset asserted at flush line 7 -> all outputs 0; after release, the flush restarts at counter 0 and flush_done needs 16 further beats.
REQ-042 flush_valid=1 in RUN -> proto_err=1 the next cycle and stays 1; the tag port is unaffected.

Source files
------------

// File: rtl/rv_tag_access_arb_pkg.sv
// Shared definitions for the tag-array access arbiter: arbiter state
// encoding and the line-select width derived from the cache geometry.
package rv_tag_access_arb_pkg;

    // FLUSH is the reset state; RUN is entered once every line is invalidated.
    typedef enum logic [0:0] {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_t;

    // Number of bits needed to select one line within a bank.
    // Never returns less than 1, so port widths stay legal.
    function automatic int calc_line_select_bits(input int cache_size,
                                                 input int line_size,
                                                 input int num_banks);
        int num_lines;
        num_lines = cache_size / (line_size * num_banks);
        return (num_lines > 1) ? $clog2(num_lines) : 1;
    endfunction

endpackage

// File: rtl/rv_tag_access_arb_if.sv
// Bus bundle for the tag-array access arbiter: flush stream, core request
// channel, tag-array port and status outputs.
interface rv_tag_access_arb_if #(
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 1,
    parameter int NUM_BANKS       = 1,
    parameter int TAG_WIDTH       = 20
);
    import rv_tag_access_arb_pkg::*;

    localparam int LINE_SELECT_BITS =
        calc_line_select_bits(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);

    // Flush stream (no back-pressure)
    logic                        flush_valid;
    logic [LINE_SELECT_BITS-1:0] flush_addr;

    // Core tag request channel
    logic                        core_req_valid;
    logic                        core_req_ready;
    logic [LINE_SELECT_BITS-1:0] core_req_line;
    logic                        core_req_rw;
    logic [TAG_WIDTH-1:0]        core_req_tag;

    // Tag-array port
    logic                        tag_ready;
    logic                        tag_en;
    logic                        tag_wr;
    logic [LINE_SELECT_BITS-1:0] tag_line;
    logic                        tag_wvalid;
    logic [TAG_WIDTH-1:0]        tag_wtag;

    // Status
    logic                        flush_done;
    logic                        proto_err;
    logic [31:0]                 stall_cnt;

    // Arbiter side
    modport slave (
        input  flush_valid, flush_addr,
        input  core_req_valid, core_req_line, core_req_rw, core_req_tag,
        input  tag_ready,
        output core_req_ready,
        output tag_en, tag_wr, tag_line, tag_wvalid, tag_wtag,
        output flush_done, proto_err, stall_cnt
    );

    // Driver / environment side
    modport master (
        output flush_valid, flush_addr,
        output core_req_valid, core_req_line, core_req_rw, core_req_tag,
        output tag_ready,
        input  core_req_ready,
        input  tag_en, tag_wr, tag_line, tag_wvalid, tag_wtag,
        input  flush_done, proto_err, stall_cnt
    );

endinterface

// File: rtl/rv_tag_req_buf.sv
// One-entry core request register. A capture always loads the entry (even
// when the old one issues in the same cycle); an issue alone empties it.
module rv_tag_req_buf #(
    parameter int LINE_W = 4,
    parameter int TAG_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_capture,
    input  logic              i_issue,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_rw,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_vld,
    output logic [LINE_W-1:0] o_line,
    output logic              o_rw,
    output logic [TAG_W-1:0]  o_tag
);

    logic              r_vld;
    logic [LINE_W-1:0] r_line;
    logic              r_rw;
    logic [TAG_W-1:0]  r_tag;

    // Entry valid flag: capture wins over issue, issue alone clears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= 1'b0;
        end else if (i_capture) begin
            r_vld <= 1'b1;
        end else if (i_issue) begin
            r_vld <= 1'b0;
        end
    end

    // Entry payload, loaded on every capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= '0;
            r_rw   <= 1'b0;
            r_tag  <= '0;
        end else if (i_capture) begin
            r_line <= i_line;
            r_rw   <= i_rw;
            r_tag  <= i_tag;
        end
    end

    assign o_vld  = r_vld;
    assign o_line = r_line;
    assign o_rw   = r_rw;
    assign o_tag  = r_tag;

endmodule

// File: rtl/rv_tag_access_arb.sv
// Tag-array access arbiter. After reset every line is invalidated from the
// external flush stream (FLUSH); afterwards core requests are buffered one
// deep and issued to the tag array when it is ready (RUN).
// Optional feature macro: RV_TAG_ARB_STALL_CNT_EN enables the saturating
// core stall-cycle counter; without it stall_cnt is constant zero.
module rv_tag_access_arb
    import rv_tag_access_arb_pkg::*;
#(
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 1,
    parameter int NUM_BANKS       = 1,
    parameter int TAG_WIDTH       = 20
) (
    input  logic                clk,
    input  logic                reset,
    rv_tag_access_arb_if.slave  bus
);

    localparam int LINE_SELECT_BITS =
        calc_line_select_bits(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
    localparam logic [LINE_SELECT_BITS:0] LAST_LINE =
        {1'b0, {LINE_SELECT_BITS{1'b1}}};

    arb_state_t                  r_state;
    arb_state_t                  w_state_next;
    logic [LINE_SELECT_BITS:0]   r_line_cnt;
    logic                        r_flush_done;
    logic                        r_proto_err;

    logic                        w_req_vld;
    logic [LINE_SELECT_BITS-1:0] w_req_line;
    logic                        w_req_rw;
    logic [TAG_WIDTH-1:0]        w_req_tag;

    logic                        w_in_flush;
    logic                        w_in_run;
    logic                        w_flush_beat;
    logic                        w_last_beat;
    logic                        w_issue;
    logic                        w_ready;
    logic                        w_capture;

    assign w_in_flush   = (r_state == ST_FLUSH);
    assign w_in_run     = (r_state == ST_RUN);
    assign w_flush_beat = !reset && w_in_flush && bus.flush_valid;
    assign w_last_beat  = w_flush_beat && (r_line_cnt == LAST_LINE);
    // Core accesses only reach the array in RUN; a request held during
    // FLUSH waits here until the first ready RUN cycle.
    assign w_issue      = !reset && w_req_vld && bus.tag_ready && w_in_run;
    assign w_ready      = !reset && (!w_req_vld || w_issue);
    assign w_capture    = bus.core_req_valid && w_ready;

    rv_tag_req_buf #(
        .LINE_W (LINE_SELECT_BITS),
        .TAG_W  (TAG_WIDTH)
    ) u_req_buf (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_capture),
        .i_issue   (w_issue),
        .i_line    (bus.core_req_line),
        .i_rw      (bus.core_req_rw),
        .i_tag     (bus.core_req_tag),
        .o_vld     (w_req_vld),
        .o_line    (w_req_line),
        .o_rw      (w_req_rw),
        .o_tag     (w_req_tag)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave FLUSH on the beat that invalidates the last line
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FLUSH: if (w_last_beat) w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_FLUSH;
        endcase
    end

    // Tag-port mux: flush beats pass straight through, core accesses come
    // from the request register; everything is quiet while in reset
    always_comb begin
        bus.tag_en     = 1'b0;
        bus.tag_wr     = 1'b0;
        bus.tag_line   = '0;
        bus.tag_wvalid = 1'b0;
        bus.tag_wtag   = '0;
        if (!reset) begin
            case (r_state)
                ST_FLUSH: begin
                    if (bus.flush_valid) begin
                        bus.tag_en   = 1'b1;
                        bus.tag_wr   = 1'b1;
                        bus.tag_line = bus.flush_addr;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        bus.tag_en     = 1'b1;
                        bus.tag_wr     = w_req_rw;
                        bus.tag_line   = w_req_line;
                        bus.tag_wvalid = w_req_rw;
                        bus.tag_wtag   = w_req_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.core_req_ready = w_ready;

    // Flush line counter, one step per accepted flush beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_cnt <= '0;
        end else if (w_flush_beat) begin
            r_line_cnt <= r_line_cnt + (LINE_SELECT_BITS + 1)'(1);
        end
    end

    // Flush-complete flag, set together with the move into RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_done <= 1'b0;
        end else if (w_last_beat) begin
            r_flush_done <= 1'b1;
        end
    end

    // Sticky protocol error: a flush beat arriving after the flush finished
    always_ff @(posedge clk) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (w_in_run && bus.flush_valid) begin
            r_proto_err <= 1'b1;
        end
    end

    assign bus.flush_done = r_flush_done;
    assign bus.proto_err  = r_proto_err;

`ifdef RV_TAG_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where the core offers a request that is not taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.core_req_valid && !w_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 32'd0;
`endif

endmodule
